spi_gate_ng: RTL and testbench

Parametrised next-generation SPI slave gateway between an external host controller and the internal port bus. It supports configurable address and data widths and all four SPI modes (CPOL/CPHA). It adds burst transfers with optional address auto-increment, and a registered, synchronised host interface. Internal ports see the same SEL/TXE/RXE port-bus semantics as before, generalised to DATA_W.

---
 rtl/spi_gate_pkg.sv | 22 ++
 rtl/spi_edge_sync.sv | 60 ++++++
 rtl/spi_gate_ng.sv | 193 +++++++++++++++++++
 tb/tb_spi_gate_ng.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_gate_pkg.sv
// Shared types, constants and helpers for the SPI slave gateway.
package spi_gate_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_LOAD,
        S_DATA
    } state_t;

    // CLK cycles between the end of the TXE cycle and the TXD capture.
    localparam int TX_LATCH_DLY = 2;

    // Depth of the SCLK/MOSI/nCS synchronisers.
    localparam int SYNC_STAGES = 2;

    // True when the sample edge is the rising synced SCLK edge.
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return cpol == cpha;
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Brings the host SPI pins into the CLK domain and turns SCLK transitions
// into single-cycle sample/shift strobes for the selected SPI mode.
module spi_edge_sync #(
    parameter bit CPOL = 1'b0,
    parameter bit CPHA = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic SCLK,
    input  logic MOSI,
    input  logic nCS,
    output logic sample_edge,
    output logic shift_edge,
    output logic cs_active,
    output logic mosi_s
);
    import spi_gate_pkg::*;

    localparam bit SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_prev;
    logic                   cs_prev;
    logic                   sclk_s;
    logic                   sclk_rise;
    logic                   sclk_fall;

    // Synchroniser chains plus one history flop each for SCLK edge detection
    // and for gating; chip select is kept active-high so a cleared chain
    // reads as "not selected".
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_sync   <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], ~nCS};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            cs_prev   <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_active = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev;
    assign sclk_fall = ~sclk_s & sclk_prev;

    // Edges are qualified by the previous-cycle select so that a final sample
    // edge landing on the same CLK as deselect still completes its word.
    assign sample_edge = cs_prev & (SAMPLE_RISE ? sclk_rise : sclk_fall);
    assign shift_edge  = cs_prev & (SAMPLE_RISE ? sclk_fall : sclk_rise);

endmodule

// File: rtl/spi_gate_ng.sv
// SPI slave gateway: an address phase selects an internal port, then words
// are exchanged in bursts with optional address auto-increment.
module spi_gate_ng #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter bit CPOL     = 1'b0,
    parameter bit CPHA     = 1'b0,
    parameter bit AUTO_INC = 1'b1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    input  logic              nCS,
    output logic [DATA_W-1:0] RXD,
    input  logic [DATA_W-1:0] TXD,
    output logic [ADDR_W-1:0] ADDR,
    output logic              SEL,
    output logic              TXE,
    output logic              RXE
);
    import spi_gate_pkg::*;

    localparam int               CNT_W     = 6;
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [1:0]       LOAD_LAST = 2'(TX_LATCH_DLY + 1);

    state_t             state;
    state_t             state_next;
    logic               sample_edge;
    logic               shift_edge;
    logic               cs_active;
    logic               mosi_s;
    logic [CNT_W-1:0]   bit_cnt;
    logic [1:0]         load_cnt;
    logic               skip_shift;
    logic [ADDR_W-1:0]  addr_sh;
    logic [DATA_W-1:0]  rx_sh;
    logic [DATA_W-1:0]  tx_sh;
    logic [ADDR_W-1:0]  addr_next;
    logic [DATA_W-1:0]  rx_next;
    logic               addr_done;
    logic               word_done;
    logic               tx_load;
    logic               txe_next;

    spi_edge_sync #(
        .CPOL (CPOL),
        .CPHA (CPHA)
    ) u_sync (
        .CLK         (CLK),
        .RST         (RST),
        .SCLK        (SCLK),
        .MOSI        (MOSI),
        .nCS         (nCS),
        .sample_edge (sample_edge),
        .shift_edge  (shift_edge),
        .cs_active   (cs_active),
        .mosi_s      (mosi_s)
    );

    assign addr_next = ADDR_W'({addr_sh, mosi_s});
    assign rx_next   = DATA_W'({rx_sh, mosi_s});
    assign MISO      = tx_sh[DATA_W-1];

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and phase strobes; deselect overrides everything except a
    // word that completes on the same cycle.
    always_comb begin
        state_next = state;
        addr_done  = 1'b0;
        word_done  = 1'b0;
        tx_load    = 1'b0;
        txe_next   = 1'b0;
        case (state)
            S_IDLE: begin
                if (cs_active) begin
                    state_next = S_ADDR;
                end
            end
            S_ADDR: begin
                if (sample_edge && bit_cnt == ADDR_LAST) begin
                    addr_done  = 1'b1;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_cnt == 2'd0) begin
                    txe_next = 1'b1;
                end
                if (load_cnt == LOAD_LAST) begin
                    tx_load    = 1'b1;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (sample_edge && bit_cnt == DATA_LAST) begin
                    word_done  = 1'b1;
                    state_next = S_LOAD;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (!cs_active) begin
            state_next = S_IDLE;
            addr_done  = 1'b0;
            tx_load    = 1'b0;
            txe_next   = 1'b0;
        end
    end

    // Datapath: shift registers, counters and the registered port-bus outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bit_cnt    <= '0;
            load_cnt   <= '0;
            skip_shift <= 1'b0;
            addr_sh    <= '0;
            rx_sh      <= '0;
            tx_sh      <= '0;
            ADDR       <= '0;
            RXD        <= '0;
            SEL        <= 1'b0;
            TXE        <= 1'b0;
            RXE        <= 1'b0;
        end else begin
            TXE <= txe_next;
            RXE <= word_done;
            if (word_done) begin
                RXD <= rx_next;
                if (AUTO_INC) begin
                    ADDR <= ADDR + ADDR_W'(1);
                end
            end
            if (addr_done) begin
                ADDR <= addr_next;
                SEL  <= 1'b1;
            end
            if (!cs_active) begin
                bit_cnt    <= '0;
                load_cnt   <= '0;
                skip_shift <= 1'b0;
                addr_sh    <= '0;
                rx_sh      <= '0;
                SEL        <= 1'b0;
            end else begin
                case (state)
                    S_ADDR: begin
                        if (sample_edge) begin
                            addr_sh <= addr_next;
                            bit_cnt <= addr_done ? '0 : bit_cnt + CNT_W'(1);
                        end
                    end
                    S_LOAD: begin
                        if (tx_load) begin
                            tx_sh      <= TXD;
                            skip_shift <= 1'b1;
                            load_cnt   <= '0;
                        end else begin
                            load_cnt <= load_cnt + 2'd1;
                        end
                    end
                    S_DATA: begin
                        if (sample_edge) begin
                            rx_sh   <= rx_next;
                            bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
                        end
                        if (shift_edge) begin
                            if (skip_shift) begin
                                skip_shift <= 1'b0;
                            end else begin
                                tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_gate_ng.sv
// Directed bench for spi_gate_ng: a default instance, four 4/8-bit instances
// (one per SPI mode) and a fixed-address instance share SCLK/MOSI/TXD; each
// has its own chip select.
module tb_spi_gate_ng;

    localparam int HALF = 8;

    logic        clk;
    logic        rst;
    logic        sclk;
    logic        mosi;
    logic [5:0]  ncs;
    logic [15:0] txd;
    logic [7:0]  txd8;

    logic        m_miso, m_sel, m_txe, m_rxe;
    logic [15:0] m_rxd;
    logic [7:0]  m_addr;
    logic        f_miso, f_sel, f_txe, f_rxe;
    logic [15:0] f_rxd;
    logic [7:0]  f_addr;
    logic        w_miso [4];
    logic        w_sel  [4];
    logic        w_txe  [4];
    logic        w_rxe  [4];
    logic [7:0]  w_rxd  [4];
    logic [3:0]  w_addr [4];

    int          sel_idx;
    logic        cur_miso, cur_sel, cur_txe, cur_rxe;
    logic [15:0] cur_rxd;
    logic [7:0]  cur_addr;

    int          tests_run;
    int          tests_failed;
    int          txe_count;
    int          rxe_count;
    bit          sel_seen;
    logic [7:0]  txe_addr  [8];
    logic [7:0]  rxe_addr  [8];
    logic [15:0] rxd_got   [8];
    logic [15:0] txd_words [8];

    assign txd8 = txd[7:0];

    spi_gate_ng u_main (
        .CLK (clk), .RST (rst), .SCLK (sclk), .MOSI (mosi), .MISO (m_miso),
        .nCS (ncs[0]), .RXD (m_rxd), .TXD (txd), .ADDR (m_addr),
        .SEL (m_sel), .TXE (m_txe), .RXE (m_rxe)
    );

    for (genvar m = 0; m < 4; m++) begin : g_mode
        spi_gate_ng #(
            .ADDR_W (4), .DATA_W (8), .CPOL ((m / 2) == 1), .CPHA ((m % 2) == 1),
            .AUTO_INC (1'b1)
        ) u_dut (
            .CLK (clk), .RST (rst), .SCLK (sclk), .MOSI (mosi), .MISO (w_miso[m]),
            .nCS (ncs[m+1]), .RXD (w_rxd[m]), .TXD (txd8), .ADDR (w_addr[m]),
            .SEL (w_sel[m]), .TXE (w_txe[m]), .RXE (w_rxe[m])
        );
    end

    spi_gate_ng #(.AUTO_INC (1'b0)) u_fixed (
        .CLK (clk), .RST (rst), .SCLK (sclk), .MOSI (mosi), .MISO (f_miso),
        .nCS (ncs[5]), .RXD (f_rxd), .TXD (txd), .ADDR (f_addr),
        .SEL (f_sel), .TXE (f_txe), .RXE (f_rxe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route the outputs of whichever instance the host is talking to.
    always_comb begin
        cur_miso = m_miso;
        cur_sel  = m_sel;
        cur_txe  = m_txe;
        cur_rxe  = m_rxe;
        cur_rxd  = m_rxd;
        cur_addr = m_addr;
        if (sel_idx >= 1 && sel_idx <= 4) begin
            cur_miso = w_miso[sel_idx-1];
            cur_sel  = w_sel[sel_idx-1];
            cur_txe  = w_txe[sel_idx-1];
            cur_rxe  = w_rxe[sel_idx-1];
            cur_rxd  = {8'h00, w_rxd[sel_idx-1]};
            cur_addr = {4'h0, w_addr[sel_idx-1]};
        end else if (sel_idx == 5) begin
            cur_miso = f_miso;
            cur_sel  = f_sel;
            cur_txe  = f_txe;
            cur_rxe  = f_rxe;
            cur_rxd  = f_rxd;
            cur_addr = f_addr;
        end
    end

    // Port model: answer each TXE with the next queued word and log strobes.
    always @(negedge clk) begin
        if (cur_txe === 1'b1) begin
            if (txe_count < 8) begin
                txe_addr[txe_count] = cur_addr;
                txd = txd_words[txe_count];
            end
            txe_count++;
        end
        if (cur_rxe === 1'b1) begin
            if (rxe_count < 8) begin
                rxe_addr[rxe_count] = cur_addr;
                rxd_got[rxe_count]  = cur_rxd;
            end
            rxe_count++;
        end
        if (cur_sel === 1'b1) sel_seen = 1'b1;
    end

    task automatic clear_log();
        txe_count = 0;
        rxe_count = 0;
        sel_seen  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            txe_addr[i]  = 8'hxx;
            rxe_addr[i]  = 8'hxx;
            rxd_got[i]   = 16'hxxxx;
            txd_words[i] = 16'h0000;
        end
    endtask

    // Host side: select instance idx and clock out nbits of stream MSB first,
    // capturing MISO at the host's sample edge. Chip select is left low.
    task automatic spi_xfer(input int idx, input bit cpol, input bit cpha,
                            input logic [63:0] stream, input int nbits,
                            output logic [63:0] miso_bits);
        miso_bits = '0;
        sel_idx   = idx;
        sclk      = cpol;
        repeat (4) @(negedge clk);
        ncs[idx] = 1'b0;
        repeat (5) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!cpha) begin
                mosi = stream[i];
                repeat (HALF) @(negedge clk);
                sclk = ~cpol;
                miso_bits = {miso_bits[62:0], cur_miso};
                repeat (HALF) @(negedge clk);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = stream[i];
                repeat (HALF) @(negedge clk);
                sclk = cpol;
                miso_bits = {miso_bits[62:0], cur_miso};
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    // Release chip select and count CLKs until SEL falls (bounded).
    task automatic end_select(input int idx, output int drop_clks);
        repeat (HALF) @(negedge clk);
        ncs[idx]  = 1'b1;
        drop_clks = 0;
        while (cur_sel !== 1'b0 && drop_clks < 10) begin
            @(negedge clk);
            drop_clks++;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        sel_idx = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({m_sel, m_txe, m_rxe, m_miso} !== 4'b0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b, expected 0000", {m_sel, m_txe, m_rxe, m_miso});
        end
        tests_run++;
        if (m_addr !== 8'h00 || m_rxd !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_regs: got addr %h rxd %h, expected 00 0000", m_addr, m_rxd);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++;
        if ({m_sel, m_txe, m_rxe} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL idle_after_reset: got %b, expected 000", {m_sel, m_txe, m_rxe});
        end
    endtask

    task automatic test_mode0_single();
        logic [63:0] mb;
        int drop;
        clear_log();
        txd_words[0] = 16'hBEEF;
        spi_xfer(0, 1'b0, 1'b0, 64'h5A1234, 24, mb);
        end_select(0, drop);
        tests_run++;
        if (sel_seen !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL single_sel: got %b, expected 1", sel_seen);
        end
        tests_run++;
        if (txe_addr[0] !== 8'h5A) begin
            tests_failed++;
            $display("[TB] FAIL single_addr: got %h, expected 5a", txe_addr[0]);
        end
        tests_run++;
        if (rxe_count != 1 || rxd_got[0] !== 16'h1234) begin
            tests_failed++;
            $display("[TB] FAIL single_rx: got %0d words first %h, expected 1 word 1234", rxe_count, rxd_got[0]);
        end
        tests_run++;
        if (mb[15:0] !== 16'hBEEF) begin
            tests_failed++;
            $display("[TB] FAIL single_miso: got %h, expected beef", mb[15:0]);
        end
        tests_run++;
        if (cur_sel !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL single_sel_drop: got %b, expected 0", cur_sel);
        end
    endtask

    task automatic test_modes();
        logic [63:0] mb;
        int drop;
        for (int m = 0; m < 4; m++) begin
            clear_log();
            txd_words[0] = 16'h003C;
            spi_xfer(m + 1, (m / 2) == 1, (m % 2) == 1, 64'h3A5, 12, mb);
            end_select(m + 1, drop);
            tests_run++;
            if (rxe_count != 1 || rxd_got[0] !== 16'h00A5) begin
                tests_failed++;
                $display("[TB] FAIL mode%0d_rx: got %0d words first %h, expected 1 word 00a5", m, rxe_count, rxd_got[0]);
            end
            tests_run++;
            if (mb[7:0] !== 8'h3C) begin
                tests_failed++;
                $display("[TB] FAIL mode%0d_miso: got %h, expected 3c", m, mb[7:0]);
            end
            tests_run++;
            if (txe_addr[0] !== 8'h03) begin
                tests_failed++;
                $display("[TB] FAIL mode%0d_addr: got %h, expected 03", m, txe_addr[0]);
            end
        end
    endtask

    task automatic test_burst_wrap();
        logic [63:0] mb;
        logic [7:0]  exp_addr [4];
        logic [15:0] exp_word [3];
        int drop;
        exp_addr = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        exp_word = '{16'h0001, 16'h0002, 16'h0003};
        clear_log();
        txd_words[0] = 16'hA001;
        txd_words[1] = 16'hA002;
        txd_words[2] = 16'hA003;
        spi_xfer(0, 1'b0, 1'b0, 64'h00FE_0001_0002_0003, 56, mb);
        end_select(0, drop);
        tests_run++;
        if (rxe_count != 3 || txe_count != 4) begin
            tests_failed++;
            $display("[TB] FAIL burst_counts: got rxe %0d txe %0d, expected rxe 3 txe 4", rxe_count, txe_count);
        end
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (txe_addr[k] !== exp_addr[k]) begin
                tests_failed++;
                $display("[TB] FAIL burst_addr%0d: got %h, expected %h", k, txe_addr[k], exp_addr[k]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if (rxd_got[k] !== exp_word[k]) begin
                tests_failed++;
                $display("[TB] FAIL burst_rx%0d: got %h, expected %h", k, rxd_got[k], exp_word[k]);
            end
        end
        tests_run++;
        if (mb[47:0] !== 48'hA001_A002_A003) begin
            tests_failed++;
            $display("[TB] FAIL burst_miso: got %h, expected a001a002a003", mb[47:0]);
        end
    endtask

    task automatic test_fixed_addr();
        logic [63:0] mb;
        int drop;
        clear_log();
        spi_xfer(5, 1'b0, 1'b0, 64'h10_CAFE_0F0F, 40, mb);
        end_select(5, drop);
        tests_run++;
        if (rxe_count != 2 || rxd_got[0] !== 16'hCAFE || rxd_got[1] !== 16'h0F0F) begin
            tests_failed++;
            $display("[TB] FAIL fixed_rx: got %0d words %h %h, expected 2 words cafe 0f0f", rxe_count, rxd_got[0], rxd_got[1]);
        end
        tests_run++;
        if (rxe_addr[0] !== 8'h10 || rxe_addr[1] !== 8'h10) begin
            tests_failed++;
            $display("[TB] FAIL fixed_addr: got %h %h, expected 10 10", rxe_addr[0], rxe_addr[1]);
        end
    endtask

    task automatic test_deselect();
        logic [63:0] mb;
        int drop;
        clear_log();
        spi_xfer(0, 1'b0, 1'b0, 64'hEFAB, 17, mb);
        end_select(0, drop);
        tests_run++;
        if (rxe_count != 0) begin
            tests_failed++;
            $display("[TB] FAIL partial_rxe: got %0d pulses, expected 0", rxe_count);
        end
        tests_run++;
        if (drop > 4 || cur_sel !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL sel_drop: got %0d clks sel %b, expected <=4 clks sel 0", drop, cur_sel);
        end
        tests_run++;
        if (cur_rxd !== 16'h0003) begin
            tests_failed++;
            $display("[TB] FAIL rxd_hold: got %h, expected 0003", cur_rxd);
        end
        clear_log();
        txd_words[0] = 16'h1357;
        spi_xfer(0, 1'b0, 1'b0, 64'h425555, 24, mb);
        end_select(0, drop);
        tests_run++;
        if (txe_addr[0] !== 8'h42 || rxe_count != 1 || rxd_got[0] !== 16'h5555) begin
            tests_failed++;
            $display("[TB] FAIL restart: got addr %h, %0d words, %h; expected addr 42, 1 word, 5555", txe_addr[0], rxe_count, rxd_got[0]);
        end
        tests_run++;
        if (mb[15:0] !== 16'h1357) begin
            tests_failed++;
            $display("[TB] FAIL restart_miso: got %h, expected 1357", mb[15:0]);
        end
    endtask

    task automatic test_reset_mid_word();
        logic [63:0] mb;
        int drop;
        clear_log();
        txd_words[0] = 16'hFFFF;
        spi_xfer(0, 1'b0, 1'b0, 64'h44B, 13, mb);
        tests_run++;
        if (cur_sel !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL pre_reset_sel: got %b, expected 1", cur_sel);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({m_sel, m_txe, m_rxe, m_miso, m_addr, m_rxd} !== 28'h0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got %h, expected 0000000", {m_sel, m_txe, m_rxe, m_miso, m_addr, m_rxd});
        end
        ncs[0] = 1'b1;
        sclk   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        clear_log();
        txd_words[0] = 16'h0F0F;
        spi_xfer(0, 1'b0, 1'b0, 64'h224321, 24, mb);
        end_select(0, drop);
        tests_run++;
        if (txe_addr[0] !== 8'h22 || rxe_count != 1 || rxd_got[0] !== 16'h4321) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_xfer: got addr %h, %0d words, %h; expected addr 22, 1 word, 4321", txe_addr[0], rxe_count, rxd_got[0]);
        end
        tests_run++;
        if (mb[15:0] !== 16'h0F0F) begin
            tests_failed++;
            $display("[TB] FAIL post_reset_miso: got %h, expected 0f0f", mb[15:0]);
        end
    endtask

    // Global time bound so the run always ends.
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        sel_idx      = 0;
        rst          = 1'b1;
        sclk         = 1'b0;
        mosi         = 1'b0;
        ncs          = 6'b111111;
        txd          = 16'h0000;
        clear_log();
        test_reset();
        test_mode0_single();
        test_modes();
        test_burst_wrap();
        test_fixed_addr();
        test_deselect();
        test_reset_mid_word();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
